muldiv_sequencer: RTL and testbench

Controller between the multicycle control unit and the shared MULT/DIV datapath. Accepts one HI/LO operation at a time, launches the multiplier or divider, holds the CPU stalled until completion, and owns the architectural HI/LO registers. Detects zero divisors before launch, and runs a watchdog so a hung unit cannot freeze the pipeline.

---
 rtl/muldiv_sequencer.sv | 136 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// HI/LO sequencer: launches the shared multiplier/divider, stalls the CPU until done, owns HI/LO.
// Build option DIV_ZERO_TRAP_EN: zero-divisor DIV sets div_zero and leaves HI/LO untouched.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic               op_sel,
  input  logic signed [31:0] op_a,
  input  logic signed [31:0] op_b,
  output logic               busy,
  output logic               mult_start,
  output logic               div_start,
  output logic signed [31:0] unit_a,
  output logic signed [31:0] unit_b,
  input  logic               mult_done,
  input  logic        [31:0] mult_hi,
  input  logic        [31:0] mult_lo,
  input  logic               div_done,
  input  logic        [31:0] div_rem,
  input  logic        [31:0] div_quo,
  output logic        [31:0] hi,
  output logic        [31:0] lo,
  output logic               div_zero,
  output logic               timeout_err
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, WRITE} state_t;

  state_t             state, state_nxt;
  logic               sel_div;
  logic [CNT_W-1:0]   wdog;
  logic [DATA_W-1:0]  res_hi_p1, res_lo_p1;
  logic               vld_p1;
  logic               sel_done, wdog_exp, b_zero;

  assign sel_done = sel_div ? div_done : mult_done;
  assign wdog_exp = (wdog == CNT_W'(TIMEOUT_CYCLES - 1));
  assign b_zero   = (unit_b == '0);

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    mult_start = 1'b0;
    div_start  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (op_valid) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        if (sel_div && b_zero) begin
          state_nxt = WRITE;
        end else begin
          mult_start = ~sel_div;
          div_start  = sel_div;
          state_nxt  = RUN;
        end
      end
      RUN:     if (sel_done || wdog_exp) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hi          <= '0;
      lo          <= '0;
      unit_a      <= '0;
      unit_b      <= '0;
      sel_div     <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (op_valid) begin
            unit_a      <= op_a;
            unit_b      <= op_b;
            sel_div     <= op_sel;
            div_zero    <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        LAUNCH: begin
          wdog   <= '0;
          vld_p1 <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
          if (sel_div && b_zero) begin
            div_zero <= 1'b1;
            vld_p1   <= 1'b0;
          end
`endif
        end
        RUN: begin
          wdog <= wdog + 1'b1;
          // done beats the watchdog when both land in the same cycle
          if (!sel_done && wdog_exp) begin
            timeout_err <= 1'b1;
            vld_p1      <= 1'b0;
          end
        end
        WRITE: begin
          if (vld_p1) begin
            hi <= res_hi_p1;
            lo <= res_lo_p1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- result staging (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (state == LAUNCH && sel_div && b_zero) begin
`ifndef DIV_ZERO_TRAP_EN
      res_hi_p1 <= unit_a;
      res_lo_p1 <= '1;
`endif
    end else if (state == RUN && sel_done) begin
      res_hi_p1 <= sel_div ? div_rem : mult_hi;
      res_lo_p1 <= sel_div ? div_quo : mult_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer with emulated multiplier/divider units.
module tb_muldiv_sequencer;
  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_sel;
  logic [31:0] op_a, op_b;
  logic        busy, mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo, div_rem, div_quo;
  logic [31:0] hi, lo;
  logic        div_zero, timeout_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_sel(op_sel),
    .op_a(op_a), .op_b(op_b), .busy(busy), .mult_start(mult_start),
    .div_start(div_start), .unit_a(unit_a), .unit_b(unit_b),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div_rem(div_rem), .div_quo(div_quo),
    .hi(hi), .lo(lo), .div_zero(div_zero), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation; n = cycles from start pulse to done (0 = unit never answers)
  task automatic run_op(input logic sel, input logic [31:0] a, input logic [31:0] b, input int n);
    logic [31:0] rh, rl;
    longint      p;
    int          busy_cnt = 0, ms = 0, ds = 0, since = -1, exp_busy;
    bit          opnd_ok = 1'b1, zero_div, tmo, exp_dz, exp_to, d;
    if (!sel) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      rh = p[63:32];
      rl = p[31:0];
    end else if (b != 0) begin
      rh = $signed(a) % $signed(b);
      rl = $signed(a) / $signed(b);
    end else begin
      rh = $urandom;
      rl = $urandom;
    end
    @(negedge clk);
    op_valid = 1'b1; op_sel = sel; op_a = a; op_b = b;
    mult_done = 1'b0; div_done = 1'b0;
    mult_hi = sel ? $urandom : rh;  mult_lo = sel ? $urandom : rl;
    div_rem = sel ? rh : $urandom;  div_quo = sel ? rl : $urandom;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (mult_start) ms++;
      if (div_start) ds++;
      if (unit_a !== a || unit_b !== b) opnd_ok = 1'b0;
      if (mult_start || div_start) since = 0;
      else if (since >= 0) since++;
      d = (n > 0 && since == n);
      if (sel) begin div_done = d; mult_done = 1'($urandom % 2); end
      else     begin mult_done = d; div_done = 1'($urandom % 2); end
      op_valid = 1'($urandom % 2); op_a = $urandom; op_b = $urandom;
    end
    op_valid = 1'b0; mult_done = 1'b0; div_done = 1'b0;

    zero_div = sel && (b == 0);
    exp_dz = 1'b0; exp_to = 1'b0;
    if (zero_div) begin
      exp_busy = 2;
`ifdef DIV_ZERO_TRAP_EN
      exp_dz = 1'b1;
`else
      exp_hi = a; exp_lo = 32'hFFFF_FFFF;
`endif
    end else begin
      tmo = (n == 0) || (n > TO);
      exp_busy = tmo ? TO + 2 : n + 2;
      exp_to = tmo;
      if (!tmo) begin exp_hi = rh; exp_lo = rl; end
    end
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
    chk("mult_starts", 64'(ms), 64'((!sel) ? 1 : 0));
    chk("div_starts", 64'(ds), 64'((sel && !zero_div) ? 1 : 0));
    chk("operands_held", 64'(opnd_ok), 64'(1));
    chk("hi", 64'(hi), 64'(exp_hi));
    chk("lo", 64'(lo), 64'(exp_lo));
    chk("div_zero", 64'(div_zero), 64'(exp_dz));
    chk("timeout_err", 64'(timeout_err), 64'(exp_to));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_starts"}, 64'({mult_start, div_start}), 64'(0));
    chk({tag, "_hilo"}, {hi, lo}, 64'(0));
    chk({tag, "_unit"}, {unit_a, unit_b}, 64'(0));
    chk({tag, "_flags"}, 64'({div_zero, timeout_err}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] a, b, ra;
    logic        s;
    int          n;
    reset = 1'b1; op_valid = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
    mult_done = 1'b0; div_done = 1'b0;
    mult_hi = '0; mult_lo = '0; div_rem = '0; div_quo = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;

    run_op(1'b0, 32'd3, -32'sd2, 4);
    run_op(1'b1, -32'sd7, 32'd2, 10);
    run_op(1'b1, 32'd5, 32'd0, 3);
    run_op(1'b0, $urandom, $urandom, 0);
    run_op(1'b0, 32'd9, 32'd11, 1);
    run_op(1'b1, 32'd100, 32'd7, TO);
    run_op(1'b0, $urandom, $urandom, TO + 1);
    run_op(1'b0, $urandom, 32'd0, 2);

    for (int i = 0; i < 25; i++) begin
      s = 1'($urandom % 2);
      a = $urandom;
      b = ($urandom % 4 == 0) ? 32'd0 : $urandom;
      if (b == 32'hFFFF_FFFF) b = 32'd3;
      n = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, TO + 2));
      run_op(s, a, b, n);
    end

    // stray mult_done and operand churn during a DIV, then reset mid-run
    ra = $urandom | 32'h1;
    @(negedge clk);
    op_valid = 1'b1; op_sel = 1'b1; op_a = ra; op_b = 32'd13;
    repeat (6) begin
      @(negedge clk);
      op_valid = 1'($urandom % 2); op_a = $urandom; op_b = $urandom;
      mult_done = 1'b1; div_done = 1'b0;
    end
    chk("midrun_busy", 64'(busy), 64'(1));
    chk("midrun_operands", {unit_a, unit_b}, {ra, 32'd13});
    reset = 1'b1; op_valid = 1'b1;
    @(negedge clk);
    check_cleared("midrun_reset");
    reset = 1'b0; op_valid = 1'b0; mult_done = 1'b0;
    exp_hi = '0; exp_lo = '0;
    run_op(1'b0, 32'd6, 32'd7, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
